latency_measure: RTL and testbench

LATENCY_MEASURE -- requirements
Module: latency_measure

---
 rtl/latency_measure.sv | 179 +++++++++++++++++
 tb/tb_latency_measure.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_measure.sv
// -----------------------------------------------------------------------------
// latency_measure
//
// Measures the number of clk cycles between a rising edge on ref_in and the
// next rising edge on echo_in. A measurement is armed by a one-cycle start
// pulse. The result is published on lat_out with a one-cycle lat_valid pulse.
// If no echo arrives before the counter saturates, the measurement is dropped
// and timeout pulses instead.
//
// Optional feature (macro LATENCY_MEASURE_AVG_EN):
//   When defined, four consecutive completed measurements are summed. Only
//   every 4th completion updates lat_out, with the truncated mean sum>>2, and
//   pulses lat_valid. A timeout or a reset clears the partial sum.
//
// Parameters:
//   LSIZE      width of the latency counter and of lat_out (bits)
//
// Ports:
//   clk        clock; all logic runs on its rising edge
//   rst        asynchronous, active-high reset
//   start      one-cycle request to arm a measurement (ignored while busy)
//   ref_in     stimulus level, synchronous to clk
//   echo_in    returned level, synchronous to clk
//   lat_out    last published latency in clk cycles; holds between updates
//   lat_valid  one-cycle pulse in the cycle lat_out shows a new value
//   busy       high while a measurement is armed (WAIT_REF) or counting (COUNT)
//   timeout    one-cycle pulse when a measurement is aborted
// -----------------------------------------------------------------------------
module latency_measure #(
    parameter int LSIZE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_in,
    input  logic             echo_in,
    output logic [LSIZE-1:0] lat_out,
    output logic             lat_valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REF,
        COUNT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LSIZE-1:0] cnt;
    logic [LSIZE-1:0] cnt_next;
    logic [LSIZE-1:0] meas;
    logic             ref_d;
    logic             echo_d;
    logic             ref_rise;
    logic             echo_rise;
    logic             capture;
    logic             abort;

    assign ref_rise  = ref_in & ~ref_d;
    assign echo_rise = echo_in & ~echo_d;

    // Result is the distance from the ref-rise cycle to the echo-rise cycle.
    // The counter is 0 in the first COUNT cycle, so the echo cycle adds one.
    // An echo in the very cycle the counter is all-ones wraps to 0; the
    // counter width sets the measurable range.
    assign meas = cnt + LSIZE'(1);

    assign busy = (state == WAIT_REF) || (state == COUNT);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_REF;
                end
            end
            WAIT_REF: begin
                // A coincident echo rise is deliberately ignored here.
                if (ref_rise) begin
                    cnt_next   = '0;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                // Further ref rises are ignored; only the echo matters now.
                if (echo_rise) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end else if (cnt == '1) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + LSIZE'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef LATENCY_MEASURE_AVG_EN
    logic [LSIZE+1:0] sum;
    logic [LSIZE+1:0] sum_total;
    logic [1:0]       idx;

    assign sum_total = sum + {2'b00, meas};
`endif

    // lat_out and lat_valid are loaded on the edge that enters DONE, so both
    // are visible together for exactly the DONE cycle. capture and abort are
    // mutually exclusive, so lat_valid and timeout never coincide.
    // NOTE: every register, edge detectors included, is cleared by reset so a
    // level held high across reset is seen as a fresh rise afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_d     <= 1'b0;
            echo_d    <= 1'b0;
            cnt       <= '0;
            lat_out   <= '0;
            lat_valid <= 1'b0;
            timeout   <= 1'b0;
`ifdef LATENCY_MEASURE_AVG_EN
            sum       <= '0;
            idx       <= '0;
`endif
        end else begin
            ref_d   <= ref_in;
            echo_d  <= echo_in;
            cnt     <= cnt_next;
            timeout <= abort;
`ifdef LATENCY_MEASURE_AVG_EN
            lat_valid <= 1'b0;
            if (abort) begin
                sum <= '0;
                idx <= '0;
            end else if (capture) begin
                if (idx == 2'd3) begin
                    lat_out   <= sum_total[LSIZE+1:2];
                    lat_valid <= 1'b1;
                    sum       <= '0;
                    idx       <= '0;
                end else begin
                    sum <= sum_total;
                    idx <= idx + 2'd1;
                end
            end
`else
            lat_valid <= capture;
            if (capture) begin
                lat_out <= meas;
            end
`endif
        end
    end

endmodule

// File: tb/tb_latency_measure.sv
// -----------------------------------------------------------------------------
// tb_latency_measure
//
// Directed, self-checking bench for latency_measure. Two instances share all
// stimulus: dut_a with the default LSIZE=10 and dut_b with LSIZE=4 so that the
// counter timeout is reachable in a few cycles. Expected values are worked out
// by hand from the cycle on which each edge is sampled.
// -----------------------------------------------------------------------------
module tb_latency_measure;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic       ref_in  = 1'b0;
    logic       echo_in = 1'b0;

    logic [9:0] lat_a;
    logic       valid_a;
    logic       busy_a;
    logic       tout_a;
    logic [3:0] lat_b;
    logic       valid_b;
    logic       busy_b;
    logic       tout_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    latency_measure dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_in    (ref_in),
        .echo_in   (echo_in),
        .lat_out   (lat_a),
        .lat_valid (valid_a),
        .busy      (busy_a),
        .timeout   (tout_a)
    );

    latency_measure #(.LSIZE(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ref_in    (ref_in),
        .echo_in   (echo_in),
        .lat_out   (lat_b),
        .lat_valid (valid_b),
        .busy      (busy_b),
        .timeout   (tout_b)
    );

    // Advance past one rising edge; outputs are then stable for sampling and
    // new inputs take effect at the following edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full measurement of n cycles, starting from IDLE with inputs low.
    task automatic measure(input int n, input bit exp_valid, input int exp_lat,
                           input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1) $display("FAIL %s_busy_armed: got %0b expected 1", tag, busy_a);
        else n_pass++;
        ref_in = 1'b1;
        step();
        for (int i = 0; i < n - 1; i++) step();
        n_checks++;
        if (valid_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL %s_counting: got valid=%0b busy=%0b expected valid=0 busy=1",
                     tag, valid_a, busy_a);
        else n_pass++;
        echo_in = 1'b1;
        step();
        n_checks++;
        if (valid_a !== exp_valid || valid_b !== exp_valid)
            $display("FAIL %s_valid: got %0b/%0b expected %0b", tag, valid_a, valid_b, exp_valid);
        else n_pass++;
        n_checks++;
        if (lat_a !== exp_lat[9:0] || lat_b !== exp_lat[3:0])
            $display("FAIL %s_lat: got %0d/%0d expected %0d", tag, lat_a, lat_b, exp_lat);
        else n_pass++;
        n_checks++;
        if (busy_a !== 1'b0 || tout_a !== 1'b0)
            $display("FAIL %s_done_flags: got busy=%0b timeout=%0b expected 0/0", tag, busy_a, tout_a);
        else n_pass++;
        ref_in  = 1'b0;
        echo_in = 1'b0;
        step();
        n_checks++;
        if (valid_a !== 1'b0 || lat_a !== exp_lat[9:0])
            $display("FAIL %s_hold: got valid=%0b lat=%0d expected valid=0 lat=%0d",
                     tag, valid_a, lat_a, exp_lat);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) step();
        n_checks++;
        if (lat_a !== 10'd0 || valid_a !== 1'b0 || busy_a !== 1'b0 || tout_a !== 1'b0)
            $display("FAIL reset_outputs: got lat=%0d valid=%0b busy=%0b timeout=%0b expected all 0",
                     lat_a, valid_a, busy_a, tout_a);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (busy_a !== 1'b0 || lat_b !== 4'd0)
            $display("FAIL reset_release: got busy=%0b lat=%0d expected 0/0", busy_a, lat_b);
        else n_pass++;
    endtask

    task automatic test_basic;
        measure(7, 1'b1, 7, "basic7");
        measure(3, 1'b1, 3, "basic3");
    endtask

    task automatic test_back_to_back;
        measure(1, 1'b1, 1, "b2b");
    endtask

    task automatic test_ignored;
        start = 1'b1;
        step();
        start   = 1'b0;
        ref_in  = 1'b1;
        echo_in = 1'b1;            // coincident echo must not end the measurement
        step();
        n_checks++;
        if (busy_a !== 1'b1 || valid_a !== 1'b0)
            $display("FAIL ign_coincident: got busy=%0b valid=%0b expected 1/0", busy_a, valid_a);
        else n_pass++;
        echo_in = 1'b0;
        ref_in  = 1'b0;
        start   = 1'b1;            // start during COUNT is dropped
        step();
        start  = 1'b0;
        ref_in = 1'b1;             // second ref rise must not restart the count
        step();
        ref_in = 1'b0;
        step();
        echo_in = 1'b1;            // echo rise four cycles after the ref rise
        step();
        n_checks++;
        if (valid_a !== 1'b1 || lat_a !== 10'd4 || lat_b !== 4'd4)
            $display("FAIL ign_lat: got valid=%0b lat=%0d/%0d expected 1 and 4",
                     valid_a, lat_a, lat_b);
        else n_pass++;
        echo_in = 1'b0;
        step();
        step();
        n_checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0)
            $display("FAIL ign_no_queue: got busy=%0b valid=%0b expected 0/0", busy_a, valid_a);
        else n_pass++;
    endtask

    task automatic test_timeout;
        start = 1'b1;
        step();
        start  = 1'b0;
        ref_in = 1'b1;
        step();
        ref_in = 1'b0;
        repeat (15) step();
        n_checks++;
        if (tout_b !== 1'b0 || busy_b !== 1'b1)
            $display("FAIL tout_early: got timeout=%0b busy=%0b expected 0/1", tout_b, busy_b);
        else n_pass++;
        step();
        n_checks++;
        if (tout_b !== 1'b1 || busy_b !== 1'b0 || valid_b !== 1'b0)
            $display("FAIL tout_pulse: got timeout=%0b busy=%0b valid=%0b expected 1/0/0",
                     tout_b, busy_b, valid_b);
        else n_pass++;
        n_checks++;
        if (lat_b !== 4'd4)
            $display("FAIL tout_lat_hold: got %0d expected 4", lat_b);
        else n_pass++;
        n_checks++;
        if (tout_a !== 1'b0 || busy_a !== 1'b1)
            $display("FAIL tout_wide_counter: got timeout=%0b busy=%0b expected 0/1", tout_a, busy_a);
        else n_pass++;
        step();
        n_checks++;
        if (tout_b !== 1'b0 || busy_b !== 1'b0)
            $display("FAIL tout_single: got timeout=%0b busy=%0b expected 0/0", tout_b, busy_b);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_count;
        measure(3, 1'b1, 3, "pre_rst");
        start = 1'b1;
        step();
        start  = 1'b0;
        ref_in = 1'b1;
        step();
        repeat (5) step();         // counter now at 5
        n_checks++;
        if (busy_a !== 1'b1)
            $display("FAIL mid_busy: got %0b expected 1", busy_a);
        else n_pass++;
        rst    = 1'b1;
        ref_in = 1'b0;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || lat_a !== 10'd0 || valid_a !== 1'b0 || tout_a !== 1'b0)
            $display("FAIL mid_async_clear: got busy=%0b lat=%0d valid=%0b timeout=%0b expected all 0",
                     busy_a, lat_a, valid_a, tout_a);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (valid_a !== 1'b0 || tout_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL mid_no_pulse: got valid=%0b timeout=%0b busy=%0b expected 0/0/0",
                     valid_a, tout_a, busy_a);
        else n_pass++;
        measure(7, 1'b1, 7, "post_rst");
    endtask

    task automatic test_avg;
        measure(5, 1'b0, 0, "avg1");
        measure(6, 1'b0, 0, "avg2");
        measure(7, 1'b0, 0, "avg3");
        measure(8, 1'b1, 6, "avg4");
    endtask

    initial begin
        test_reset();
`ifdef LATENCY_MEASURE_AVG_EN
        test_avg();
`else
        test_basic();
        test_back_to_back();
        test_ignored();
        test_timeout();
        test_reset_mid_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
